// File: rtl/fwvip_wb_pkg.sv
// Shared types and helpers for the Wishbone target memory model.
// Holds the target FSM state type, the wait-state counter width and
// the byte-lane select to bit-mask expansion used by the memory array.
package fwvip_wb_pkg;

  localparam int FWVIP_WB_WAIT_W    = 4;
  // Widest bus the mask helper supports: 16 lanes = 128 data bits.
  localparam int FWVIP_WB_MAX_LANES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fwvip_wb_tgt_state_e;

  // Expand one select bit per byte lane into eight mask bits.
  function automatic logic [8*FWVIP_WB_MAX_LANES-1:0] sel_to_mask(
    input logic [FWVIP_WB_MAX_LANES-1:0] sel
  );
    logic [8*FWVIP_WB_MAX_LANES-1:0] mask;
    mask = '0;
    for (int i = 0; i < FWVIP_WB_MAX_LANES; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/fwvip_wb_target_mem_array.sv
// Single-port DEPTH x DATA_WIDTH backing store for the Wishbone target.
// Per-byte write enables; registered read port that returns zero in
// de-selected lanes and on write accesses.
module fwvip_wb_target_mem_array
  import fwvip_wb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 256,
  localparam int SEL_W      = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [SEL_W-1:0]      be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0]           mem [DEPTH];
  logic [8*FWVIP_WB_MAX_LANES-1:0] mask_full;
  logic [DATA_WIDTH-1:0]           mask;

  // Byte-lane mask for the read data path.
  // NOTE: every variable in an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    mask_full = sel_to_mask(FWVIP_WB_MAX_LANES'(be));
    mask      = mask_full[DATA_WIDTH-1:0];
  end

  if (DATA_WIDTH < 8*FWVIP_WB_MAX_LANES) begin : g_mask_sink
    logic unused_mask_hi;
    assign unused_mask_hi = ^mask_full[8*FWVIP_WB_MAX_LANES-1:DATA_WIDTH];
  end

  // Byte-enabled write into the array.
  // NOTE: the array has no reset: contents must survive a bus reset, and a resettable RAM cannot map onto memory macros.
  always_ff @(posedge clock) begin
    if (en && we) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read port.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (en) rdata <= we ? '0 : (mem[idx] & mask);
  end

endmodule

// File: rtl/fwvip_wb_target_mem.sv
// Wishbone classic-cycle target with byte-addressable backing memory and
// a runtime-programmable wait-state count. One transfer at a time; each is
// answered with a one-cycle registered ack (or err).
// Optional feature macro: FWVIP_WB_TARGET_MEM_ERR_EN -- word indices >= DEPTH
// complete with err; without it, the index wraps modulo DEPTH and err is 0.
module fwvip_wb_target_mem
  import fwvip_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cyc,
  input  logic                       stb,
  input  logic                       we,
  input  logic [ADDR_WIDTH-1:0]      adr,
  input  logic [DATA_WIDTH/8-1:0]    sel,
  input  logic [DATA_WIDTH-1:0]      dat_w,
  output logic [DATA_WIDTH-1:0]      dat_r,
  output logic                       ack,
  output logic                       err,
  input  logic [FWVIP_WB_WAIT_W-1:0] wait_cycles
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [FWVIP_WB_WAIT_W-1:0] CNT_ONE = FWVIP_WB_WAIT_W'(1);

  fwvip_wb_tgt_state_e        state;
  logic [FWVIP_WB_WAIT_W-1:0] count;
  logic                       we_q;
  logic [ADDR_WIDTH-1:0]      adr_q;
  logic [SEL_W-1:0]           sel_q;
  logic [DATA_WIDTH-1:0]      dat_w_q;
  logic                       oor_q;
  logic                       ack_q;
  logic                       err_q;

  logic                       req;
  logic                       in_idle;
  logic                       go_resp;
  logic                       oor;
  logic                       we_m;
  logic [ADDR_WIDTH-1:0]      adr_m;
  logic [SEL_W-1:0]           sel_m;
  logic [DATA_WIDTH-1:0]      dat_w_m;
  logic [SEL_W-1:0]           lane_en;
  logic [IDX_W-1:0]           idx;

  // Use live inputs while IDLE (entering RESP directly) and captured copies
  // from WAIT onwards; memory access fires on the edge that enters RESP.
  always_comb begin
    req     = cyc & stb;
    in_idle = (state == ST_IDLE);
    we_m    = in_idle ? we    : we_q;
    adr_m   = in_idle ? adr   : adr_q;
    sel_m   = in_idle ? sel   : sel_q;
    dat_w_m = in_idle ? dat_w : dat_w_q;
`ifdef FWVIP_WB_TARGET_MEM_ERR_EN
    oor     = (adr_m >> OFF_W) >= ADDR_WIDTH'(DEPTH);
`else
    oor     = 1'b0;
`endif
    // An out-of-range access still takes the array slot, but with no lanes
    // enabled: nothing is written and the read data comes back as zero.
    lane_en = oor ? '0 : sel_m;
    idx     = adr_m[OFF_W +: IDX_W];
    go_resp = (in_idle && req && (wait_cycles == '0)) ||
              ((state == ST_WAIT) && cyc && (count == CNT_ONE));
  end

  // Transfer FSM: capture the request, count wait states, pulse ack/err once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_w_q <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            adr_q   <= adr;
            sel_q   <= sel;
            dat_w_q <= dat_w;
            oor_q   <= oor;
            count   <= wait_cycles;
            state   <= (wait_cycles != '0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (!cyc) begin
            // Initiator abandoned the cycle: no write, no response.
            state <= ST_IDLE;
            count <= '0;
          end else begin
            count <= count - CNT_ONE;
            if (count == CNT_ONE) state <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack_q <= ~oor_q;
          err_q <= oor_q;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ack = ack_q;

`ifdef FWVIP_WB_TARGET_MEM_ERR_EN
  assign err = err_q;
`else
  assign err = 1'b0;
  logic unused_err_q;
  assign unused_err_q = err_q;
`endif

  // Low (byte-offset) address bits, and in the aliasing build the bits above
  // the index, carry no meaning here.
  logic unused_adr_bits;
  assign unused_adr_bits = ^adr_m;

  fwvip_wb_target_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .en    (go_resp),
    .we    (we_m),
    .be    (lane_en),
    .idx   (idx),
    .wdata (dat_w_m),
    .rdata (dat_r)
  );

endmodule

// File: tb/tb_fwvip_wb_target_mem.sv
// Self-checking bench for fwvip_wb_target_mem (default 32/32/256 build).
// Expected responses are queued when a transfer is issued and popped by a
// monitor when ack/err appears; scenario tasks check timing inline.
module tb_fwvip_wb_target_mem;

  logic        clock;
  logic        reset;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic [3:0]  wait_cycles;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic        is_err;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  fwvip_wb_target_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (256)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cyc         (cyc),
    .stb         (stb),
    .we          (we),
    .adr         (adr),
    .sel         (sel),
    .dat_w       (dat_w),
    .dat_r       (dat_r),
    .ack         (ack),
    .err         (err),
    .wait_cycles (wait_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && (ack || err)) begin
      n_compared++;
      if (sb.size() == 0) begin
        n_mismatched++;
        $display("FAIL sb_unexpected: ack=%b err=%b with no transfer outstanding", ack, err);
      end else begin
        e = sb.pop_front();
        if (ack !== !e.is_err || err !== e.is_err || (e.chk_data && dat_r !== e.data)) begin
          n_mismatched++;
          $display("FAIL sb_resp: got ack=%b err=%b dat_r=%h, want ack=%b err=%b dat_r=%h",
                   ack, err, dat_r, !e.is_err, e.is_err, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic is_err, input logic chk, input logic [31:0] d);
    exp_t e;
    e.is_err   = is_err;
    e.chk_data = chk;
    e.data     = d;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // One transfer. lat = edges from the sampling edge until ack/err is seen
  // (-1 on timeout); one_cycle = response gone one cycle later.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [3:0] wc,
                          output int lat, output logic one_cycle);
    lat       = -1;
    one_cycle = 1'b0;
    @(negedge clock);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d; wait_cycles = wc;
    @(posedge clock); #1;
    // Scramble everything but cyc/stb: the target must use captured values.
    we = ~w; adr = a ^ 32'h4; sel = ~s; dat_w = ~d; wait_cycles = 4'hF;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (ack || err) begin
        lat = i;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    if (lat > 0) begin
      @(posedge clock); #1;
      one_cycle = !ack && !err;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    n_compared++;
    if (ack !== 1'b0 || err !== 1'b0 || dat_r !== 32'h0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: ack=%b err=%b dat_r=%h, want 0 0 00000000", ack, err, dat_r);
    end
    @(negedge clock); reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_compared++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_idle: ack=%b err=%b after release, want 0 0", ack, err);
    end
  endtask

  task automatic test_w0_write_read();
    int lat; logic one;
    push_exp(1'b0, 1'b0, 32'h0);
    bus_xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd0, lat, one);
    n_compared++;
    if (lat !== 1 || one !== 1'b1) begin
      n_mismatched++;
      $display("FAIL w0_write_timing: latency=%0d single=%b, want 1 1", lat, one);
    end
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    bus_xfer(1'b0, 32'h10, 4'hF, 32'h0, 4'd0, lat, one);
    n_compared++;
    if (lat !== 1 || one !== 1'b1) begin
      n_mismatched++;
      $display("FAIL w0_read_timing: latency=%0d single=%b, want 1 1", lat, one);
    end
  endtask

  task automatic test_byte_lanes();
    int lat; logic one;
    push_exp(1'b0, 1'b0, 32'h0);
    bus_xfer(1'b1, 32'h20, 4'hF, 32'h11223344, 4'd0, lat, one);
    push_exp(1'b0, 1'b0, 32'h0);
    bus_xfer(1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 4'd1, lat, one);
    push_exp(1'b0, 1'b1, 32'h11BB33DD);
    bus_xfer(1'b0, 32'h20, 4'hF, 32'h0, 4'd0, lat, one);
    push_exp(1'b0, 1'b1, 32'h000033DD);
    bus_xfer(1'b0, 32'h22, 4'h3, 32'h0, 4'd2, lat, one);
  endtask

  task automatic test_wait_states();
    int lat; logic one;
    logic [3:0] ws [4] = '{4'd5, 4'd15, 4'd1, 4'd3};
    foreach (ws[k]) begin
      push_exp(1'b0, 1'b1, 32'hDEADBEEF);
      bus_xfer(1'b0, 32'h10, 4'hF, 32'h0, ws[k], lat, one);
      n_compared++;
      if (lat !== int'(ws[k]) + 1 || one !== 1'b1) begin
        n_mismatched++;
        $display("FAIL wait_states_W%0d: latency=%0d single=%b, want %0d 1",
                 ws[k], lat, one, int'(ws[k]) + 1);
      end
    end
  endtask

  task automatic test_abort();
    int lat; logic one; int seen;
    push_exp(1'b0, 1'b0, 32'h0);
    bus_xfer(1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 4'd0, lat, one);
    @(negedge clock);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; sel = 4'hF;
    dat_w = 32'h12345678; wait_cycles = 4'd4;
    repeat (3) @(posedge clock);
    @(negedge clock); cyc = 1'b0; stb = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (ack || err) seen++;
    end
    n_compared++;
    if (seen !== 0) begin
      n_mismatched++;
      $display("FAIL abort_no_resp: %0d response cycles, want 0", seen);
    end
    push_exp(1'b0, 1'b1, 32'hCAFEF00D);
    bus_xfer(1'b0, 32'h30, 4'hF, 32'h0, 4'd0, lat, one);
  endtask

  task automatic test_reset_mid();
    int lat; logic one;
    @(negedge clock);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF; wait_cycles = 4'd8;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    #1;
    n_compared++;
    if (ack !== 1'b0 || err !== 1'b0 || dat_r !== 32'h0) begin
      n_mismatched++;
      $display("FAIL reset_mid_outputs: ack=%b err=%b dat_r=%h, want 0 0 00000000", ack, err, dat_r);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clock); reset = 1'b0;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    bus_xfer(1'b0, 32'h10, 4'hF, 32'h0, 4'd0, lat, one);
    n_compared++;
    if (lat !== 1) begin
      n_mismatched++;
      $display("FAIL reset_mid_recover: latency=%0d, want 1", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic a1, a2, a3;
    push_exp(1'b0, 1'b0, 32'h0);
    push_exp(1'b0, 1'b1, 32'h01020304);
    @(negedge clock);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF;
    dat_w = 32'h01020304; wait_cycles = 4'd0;
    @(posedge clock);
    @(posedge clock); #1; a1 = ack;
    @(negedge clock); we = 1'b0; dat_w = 32'hFFFFFFFF;
    @(posedge clock); #1; a2 = ack;
    @(posedge clock); #1; a3 = ack;
    cyc = 1'b0; stb = 1'b0;
    n_compared++;
    if ({a1, a2, a3} !== 3'b101) begin
      n_mismatched++;
      $display("FAIL back_to_back_acks: pattern=%b, want 101", {a1, a2, a3});
    end
    @(posedge clock); #1;
    n_compared++;
    if (ack !== 1'b0) begin
      n_mismatched++;
      $display("FAIL back_to_back_stop: ack=%b after stb dropped, want 0", ack);
    end
  endtask

  task automatic test_random();
    int lat; logic one;
    logic [31:0] model [8];
    logic [3:0]  s;
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      push_exp(1'b0, 1'b0, 32'h0);
      bus_xfer(1'b1, 32'h100 + 32'(4*i), 4'hF, model[i], 4'($urandom_range(3, 0)), lat, one);
    end
    for (int i = 7; i >= 0; i--) begin
      s = 4'($urandom_range(15, 0));
      push_exp(1'b0, 1'b1, model[i] & lane_mask(s));
      bus_xfer(1'b0, 32'h100 + 32'(4*i), s, 32'h0, 4'($urandom_range(3, 0)), lat, one);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic one;
`ifdef FWVIP_WB_TARGET_MEM_ERR_EN
    push_exp(1'b0, 1'b0, 32'h0);
    bus_xfer(1'b1, 32'h0, 4'hF, 32'h0BADC0DE, 4'd0, lat, one);
    push_exp(1'b1, 1'b0, 32'h0);
    bus_xfer(1'b1, 32'h400, 4'hF, 32'h55555555, 4'd2, lat, one);
    n_compared++;
    if (lat !== 3 || one !== 1'b1) begin
      n_mismatched++;
      $display("FAIL oor_err_timing: latency=%0d single=%b, want 3 1", lat, one);
    end
    push_exp(1'b1, 1'b1, 32'h0);
    bus_xfer(1'b0, 32'h400, 4'hF, 32'h0, 4'd0, lat, one);
    push_exp(1'b0, 1'b1, 32'h0BADC0DE);
    bus_xfer(1'b0, 32'h0, 4'hF, 32'h0, 4'd0, lat, one);
`else
    push_exp(1'b0, 1'b0, 32'h0);
    bus_xfer(1'b1, 32'h400, 4'hF, 32'h600DF00D, 4'd2, lat, one);
    n_compared++;
    if (lat !== 3 || one !== 1'b1) begin
      n_mismatched++;
      $display("FAIL oor_alias_timing: latency=%0d single=%b, want 3 1", lat, one);
    end
    push_exp(1'b0, 1'b1, 32'h600DF00D);
    bus_xfer(1'b0, 32'h0, 4'hF, 32'h0, 4'd0, lat, one);
`endif
  endtask

  // Ack and err must never be high together.
  always @(negedge clock) begin
    if (ack && err) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL ack_err_both: ack=%b err=%b, want never both", ack, err);
    end
  end

  initial begin
    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat_w = '0; wait_cycles = '0;
    test_reset();
    test_w0_write_read();
    test_byte_lanes();
    test_wait_states();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_out_of_range();
    repeat (4) @(posedge clock);
    #1;
    n_compared++;
    if (sb.size() !== 0) begin
      n_mismatched++;
      $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
